alu_sweep_driver: RTL and testbench



---
 rtl/alu_sweep_driver.sv | 104 ++++++++++
 tb/tb_alu_sweep_driver.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/alu_sweep_driver.sv
// Self-checking stimulus master for a 2-bit-opcode ALU. It sweeps every
// {op, inA, inB} vector, checks the returned ans and reports pass/fail.
module alu_sweep_driver #(
   parameter int unsigned W    = 4,
   parameter int unsigned HOLD = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [W-1:0]      inA,
   output logic [W-1:0]      inB,
   output logic [1:0]        op,
   input  logic [W-1:0]      ans,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [15:0]       err_cnt,
   output logic              fail_valid,
   output logic [2+3*W-1:0]  fail_vec
);

   localparam int unsigned VW = 2*W + 2;
   localparam logic [7:0]  HOLD_LAST = 8'(HOLD - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state;
   logic [VW-1:0]   vec;
   logic [7:0]      hold_cnt;
   logic [W-1:0]    expected;
   logic            mismatch;
   logic [15:0]     err_next;

   // Vector index k = {op, inA, inB}; the ALU inputs come straight off this register.
   assign {op, inA, inB} = vec;

   always_comb begin
      expected = '0;
      case (op)
         2'b00: expected = inA + inB;
         2'b01: expected = inA - inB;
         2'b10: expected = inA & inB;
         2'b11: expected = inA | inB;
         default: expected = '0;
      endcase
   end

   assign mismatch = (ans != expected);
   assign err_next = (mismatch && (err_cnt != 16'hFFFF)) ? err_cnt + 16'd1 : err_cnt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         vec        <= '0;
         hold_cnt   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_cnt    <= '0;
         fail_valid <= 1'b0;
         fail_vec   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= RUN;
                  vec        <= '0;
                  hold_cnt   <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_cnt    <= '0;
                  fail_valid <= 1'b0;
                  fail_vec   <= '0;
               end
            end
            RUN: begin
               if (hold_cnt == HOLD_LAST) begin
                  // Sample cycle: score this vector and advance on the same edge.
                  err_cnt  <= err_next;
                  hold_cnt <= '0;
                  if (mismatch && !fail_valid) begin
                     fail_valid <= 1'b1;
                     fail_vec   <= {op, inA, inB, ans};
                  end
                  if (vec == '1) begin
                     state <= DONE;
                     vec   <= '0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     pass  <= (err_next == 16'd0);
                  end else begin
                     vec <= vec + 1'b1;
                  end
               end else begin
                  hold_cnt <= hold_cnt + 8'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_sweep_driver.sv
// Bench for alu_sweep_driver: a behavioural ALU with selectable faults feeds
// the HOLD=4 instance; a second HOLD=1 instance sees a correct ALU.
module tb_alu_sweep_driver;

   localparam int unsigned W    = 4;
   localparam int unsigned HOLD = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start, start1;
   logic [3:0]  inA, inB, ans, inA1, inB1, ans1;
   logic [1:0]  op, op1;
   logic        busy, done, pass, fail_valid;
   logic        busy1, done1, pass1, fail_valid1;
   logic [15:0] err_cnt, err_cnt1;
   logic [13:0] fail_vec, fail_vec1;
   int          fault;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   alu_sweep_driver #(.W(W), .HOLD(HOLD)) dut (
      .clk(clk), .reset(reset), .start(start), .inA(inA), .inB(inB), .op(op),
      .ans(ans), .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
      .fail_valid(fail_valid), .fail_vec(fail_vec)
   );

   alu_sweep_driver #(.W(W), .HOLD(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .inA(inA1), .inB(inB1), .op(op1),
      .ans(ans1), .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
      .fail_valid(fail_valid1), .fail_vec(fail_vec1)
   );

   // fault 0: correct, 1: sub computes add, 2: ans stuck at 0
   always_comb begin
      ans = '0;
      case (op)
         2'b00: ans = inA + inB;
         2'b01: ans = (fault == 1) ? inA + inB : inA - inB;
         2'b10: ans = inA & inB;
         2'b11: ans = inA | inB;
         default: ans = '0;
      endcase
      if (fault == 2) ans = '0;
   end

   always_comb begin
      ans1 = '0;
      case (op1)
         2'b00: ans1 = inA1 + inB1;
         2'b01: ans1 = inA1 - inB1;
         2'b10: ans1 = inA1 & inB1;
         2'b11: ans1 = inA1 | inB1;
         default: ans1 = '0;
      endcase
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Pulses start, checks the restart state, then counts busy cycles.
   // Extra start pulses mid-run must not disturb the sweep.
   task automatic sweep0(output int cyc);
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_busy", 32'(busy), 32'd1);
      chk("start_done", 32'(done), 32'd0);
      chk("start_vec", 32'({op, inA, inB}), 32'd0);
      chk("start_err", 32'(err_cnt), 32'd0);
      chk("start_fv", 32'(fail_valid), 32'd0);
      cyc = 0;
      while (busy === 1'b1 && cyc < 20000) begin
         cyc++;
         if (cyc == 50) start = 1'b1;
         if (cyc == 52) start = 1'b0;
         if (cyc == 61) chk("mid_vec", 32'({op, inA, inB}), 32'((cyc - 1) / HOLD));
         @(negedge clk);
      end
   endtask

   typedef struct {
      int          fault;
      logic [15:0] exp_err;
      logic        exp_fv;
      logic [13:0] exp_vec;
      logic        exp_pass;
   } vec_t;

   vec_t tbl[4];

   initial begin
      int cyc;
      int bad;

      tbl[0] = '{0, 16'd0,   1'b0, 14'd0, 1'b1};
      // inB=0 and inB=8 both give a+b == a-b mod 16
      tbl[1] = '{1, 16'd224, 1'b1, {2'b01, 4'h0, 4'h1, 4'h1}, 1'b0};
      // true result zero: 16 add + 16 sub + 81 and + 1 or = 114
      tbl[2] = '{2, 16'd910, 1'b1, {2'b00, 4'h0, 4'h1, 4'h0}, 1'b0};
      tbl[3] = '{0, 16'd0,   1'b0, 14'd0, 1'b1};

      fault = 0; start = 1'b0; start1 = 1'b0; reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_pass", 32'(pass), 32'd0);
      chk("rst_vec", 32'({op, inA, inB}), 32'd0);
      chk("rst_err", 32'(err_cnt), 32'd0);
      chk("rst_fv", 32'(fail_valid), 32'd0);
      chk("rst_fvec", 32'(fail_vec), 32'd0);
      chk("rst1_busy", 32'(busy1), 32'd0);

      for (int i = 0; i < 4; i++) begin
         fault = tbl[i].fault;
         sweep0(cyc);
         chk("len", 32'(cyc), 32'(1024 * HOLD));
         chk("done", 32'(done), 32'd1);
         chk("pass", 32'(pass), 32'(tbl[i].exp_pass));
         chk("err_cnt", 32'(err_cnt), 32'(tbl[i].exp_err));
         chk("fail_valid", 32'(fail_valid), 32'(tbl[i].exp_fv));
         chk("fail_vec", 32'(fail_vec), 32'(tbl[i].exp_vec));
         chk("end_vec", 32'({op, inA, inB}), 32'd0);
         repeat (3) @(negedge clk);
         chk("done_hold", 32'(done), 32'd1);
         chk("err_hold", 32'(err_cnt), 32'(tbl[i].exp_err));
      end

      // Reset mid-sweep with errors already accumulated.
      fault = 2;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (99) @(negedge clk);
      chk("pre_rst_err", 32'(err_cnt != 0), 32'd1);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      chk("mrst_pass", 32'(pass), 32'd0);
      chk("mrst_vec", 32'({op, inA, inB}), 32'd0);
      chk("mrst_err", 32'(err_cnt), 32'd0);
      chk("mrst_fv", 32'(fail_valid), 32'd0);
      chk("mrst_fvec", 32'(fail_vec), 32'd0);
      repeat (3) @(negedge clk);
      chk("mrst_idle", 32'(busy), 32'd0);

      fault = 0;
      sweep0(cyc);
      chk("clean_len", 32'(cyc), 32'(1024 * HOLD));
      chk("clean_pass", 32'(pass), 32'd1);
      chk("clean_err", 32'(err_cnt), 32'd0);

      // Reset and start together: reset wins.
      reset = 1'b1; start = 1'b1;
      @(negedge clk); reset = 1'b0; start = 1'b0;
      chk("rs_busy", 32'(busy), 32'd0);
      chk("rs_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("rs_idle", 32'(busy), 32'd0);

      // HOLD=1: one vector per cycle in {op, inA, inB} order.
      start1 = 1'b1;
      @(negedge clk); start1 = 1'b0;
      cyc = 0; bad = 0;
      while (busy1 === 1'b1 && cyc < 5000) begin
         cyc++;
         if ({op1, inA1, inB1} !== 10'(cyc - 1)) bad++;
         @(negedge clk);
      end
      chk("h1_len", 32'(cyc), 32'd1024);
      chk("h1_order_bad", 32'(bad), 32'd0);
      chk("h1_done", 32'(done1), 32'd1);
      chk("h1_pass", 32'(pass1), 32'd1);
      chk("h1_err", 32'(err_cnt1), 32'd0);
      chk("h1_fv", 32'(fail_valid1), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
